fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch stage for the 5-stage pipeline CPU. It owns the PC, issues requests to instruction memory through a request/grant/response handshake, and buffers returned instructions in a DEPTH-entry prefetch queue. It presents one instruction per cycle to the IF/ID boundary. It replaces the single-register PC/IF path with stall handling (decode back-pressure) and redirect handling (branch/jump flush with discard of in-flight responses).

## Interface
- XLEN, 32: PC and instruction width.
- DEPTH, 4: prefetch queue entries (power of two, ≥2); also the maximum number of outstanding memory requests.
- RESET_PC, 0: fetch address after reset.

Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  fetch enable; no new requests while low.
- imem_req_o  out  1  request valid.
- imem_addr_o  out  XLEN  request address; word-aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in order, ≥1 cycle after grant.
- imem_rdata_i  in  XLEN  response instruction.
- id_ready_i  in  1  decode consumes the head this cycle; low means stall, from the hazard unit.
- redirect_i  in  1  branch taken or jump; flush.
- redirect_pc_i  in  XLEN  redirect target.
- inst_valid_o  out  1  queue head valid.
- inst_o  out  XLEN  head instruction; NOP (all zero) when not valid.
- pc_plus4_o  out  XLEN  head address + 4; feeds the branch adder.

## Operation
- **State**
  - fetch_pc register.
  - Queue: circular buffer with rd/wr pointers and a count.
  - outstanding counter (granted, not yet returned), range 0..DEPTH.
  - discard counter, range 0..DEPTH.
- **Credit rule:** imem_req_o = start_i & !redirect_i & (count + outstanding < DEPTH). This guarantees a queue slot for every granted request, so overflow cannot occur.
- **Grant** (req & gnt): fetch_pc ← fetch_pc + 4, modulo 2^XLEN (wrap silent). outstanding +1.
- **Address hold:** imem_addr_o = fetch_pc and stays stable while req & !gnt. The request may be withdrawn only by redirect_i or start_i falling.
- **Response** (rvalid): outstanding −1.
  - discard > 0: drop the response, discard −1.
  - otherwise: write {rdata, address+4} to the queue. The address comes from a parallel PC tag queue.
- **Pop** (inst_valid_o & id_ready_i): rd pointer +1.
- **Redirect**, highest priority:
  - Queue is emptied.
  - fetch_pc ← redirect_pc_i.
  - discard ← outstanding + grant_this_cycle − rvalid_this_cycle, i.e. every response still due is dropped.
  - Any pop, write or grant in the same cycle is ignored for queue contents.
- **Simultaneous push and pop:** count unchanged; both pointers advance.
- **start_i low:** outstanding requests still complete into the queue; decode may still drain it.

## Timing
- **Reset values:**
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - inst_valid_o=0, inst_o=0, pc_plus4_o=0.
  - All counters and pointers 0.
- **Latency:**
  - rvalid in cycle N gives inst_valid_o in N+1. The queue is registered, with no bypass.
  - Best case, request to decode: grant in cycle 0, rvalid in 1, valid in 2.
- **Throughput:** one instruction per cycle in steady state when the memory grants every cycle with 1-cycle response.
- **Redirect in cycle N:**
  - inst_valid_o=0 in N+1.
  - First request to redirect_pc_i is presented in N+1.
  - Its instruction becomes valid no earlier than N+3.
- **Reset mid-operation:** all state clears immediately. Responses arriving after reset deasserts are not tracked; the memory is reset by the same rst_i.
- Stall (id_ready_i=0) holds inst_o and pc_plus4_o stable.

## Structure
- **cpu_pkg:** XLEN default, NOP constant (32'h0), RESET_PC default, and the fetch entry struct {inst, pc_plus4}.
- **Sub-module fetch_fifo:** DEPTH-entry circular buffer, parametrised on width. Exposes push, pop, flush, count, head. fetch_unit keeps the PC, credit, outstanding and discard logic.

## Test plan
- **Reset then start:** start_i=1, gnt=1 every cycle, 1-cycle response. Required:
  - Addresses 0, 4, 8… on consecutive cycles.
  - inst_valid_o first high 2 cycles after the first grant.
  - pc_plus4_o = 4, 8, 12…
- **Stall fill:** id_ready_i=0 with DEPTH=4. Required:
  - Exactly 4 grants, then imem_req_o=0.
  - Head held at address 0.
  - Releasing the stall resumes requests within 1 cycle.
- **Redirect with in-flight responses:** 3-cycle memory latency, 2 outstanding. Assert redirect_i with target 0x100. Required:
  - Both late responses are dropped.
  - Next valid instruction has pc_plus4_o=0x104.
  - imem_addr_o=0x100 in the cycle after the redirect.
- **Redirect coincident with rvalid and pop:** required:
  - That response is dropped.
  - Queue is empty next cycle.
  - No discard counter underflow.
- **Grant withheld:** gnt=0 for 3 cycles. Required:
  - imem_addr_o stable throughout.
  - Exactly one fetch_pc increment when the grant arrives.
- **Wrap:** RESET_PC=0xFFFFFFFC. Required: second request address is 0x00000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, constants and fetch entry layout for the pipeline
package cpu_pkg;
   localparam int XLEN_DEF = 32;
   localparam logic [XLEN_DEF-1:0] NOP = 32'h0;
   localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0;
   typedef struct packed {
      logic [XLEN_DEF-1:0] inst;
      logic [XLEN_DEF-1:0] pc_plus4;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer with flush, used for the prefetch and PC tag queues
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [AW:0]      count,
   output logic [WIDTH-1:0] head
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic do_push;
   logic do_pop;
   assign do_pop  = pop & (count != '0) & !flush;
   assign do_push = push & !flush & ((count != FULL) | do_pop);
   assign head    = mem[rd_ptr];
   // pointer and occupancy update; flush empties the buffer and overrides push/pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   // storage carries no reset; the head is only consumed while count is non-zero
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues credit-limited instruction fetches and buffers them for decode
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            id_ready_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            inst_valid_o,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_plus4_o
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);
   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   tag_head;
   logic [2*XLEN-1:0] head;
   logic [CW-1:0]     count;
   logic [CW-1:0]     tag_count;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     discard;
   logic [CW-1:0]     next_out;
   logic              grant;
   logic              rsp;
   logic              keep;
   // a request is only made when a queue slot is guaranteed for its response
   assign imem_req_o  = start_i & !redirect_i & (({1'b0, count} + {1'b0, outstanding}) < CREDITS);
   assign imem_addr_o = fetch_pc;
   assign grant       = imem_req_o & imem_gnt_i;
   assign rsp         = imem_rvalid_i & (outstanding != '0);
   assign keep        = imem_rvalid_i & (discard == '0) & (tag_count != '0);
   assign next_out    = outstanding + CW'(grant) - CW'(rsp);
   // fetch address, in-flight count and pending drops; a redirect retargets and dooms everything still due
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= next_out;
         if (redirect_i) begin
            fetch_pc <= redirect_pc_i & ~XLEN'(3);
            discard  <= next_out;
         end else begin
            if (grant) fetch_pc <= fetch_pc + XLEN'(4);
            if (rsp && discard != '0) discard <= discard - 1'b1;
         end
      end
   end
   fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (grant),
      .pop   (keep),
      .flush (redirect_i),
      .wdata (fetch_pc + XLEN'(4)),
      .count (tag_count),
      .head  (tag_head)
   );
   fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_inst_q (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (keep),
      .pop   (inst_valid_o & id_ready_i),
      .flush (redirect_i),
      .wdata ({imem_rdata_i, tag_head}),
      .count (count),
      .head  (head)
   );
   assign inst_valid_o = count != '0;
   assign inst_o       = inst_valid_o ? head[2*XLEN-1:XLEN] : XLEN'(NOP);
   assign pc_plus4_o   = inst_valid_o ? head[XLEN-1:0] : '0;
endmodule
